// File: rtl/iic_master_port.sv
// iic_master_port: single-channel IIC master that turns command/stream requests into csn/scl/sdo/tri bus signals
module iic_master_port #(
  parameter int MD_SIM_ABLE = 0,
  parameter int WD_ERR_INFO = 4,
  parameter int NB_CLK_DIV = 125,
  parameter int WD_BYTE_CNT = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   s_cmd_valid,
  output logic                   s_cmd_ready,
  input  logic [6:0]             s_cmd_addr,
  input  logic                   s_cmd_rnw,
  input  logic [WD_BYTE_CNT-1:0] s_cmd_len,
  input  logic                   s_wdata_valid,
  output logic                   s_wdata_ready,
  input  logic [7:0]             s_wdata_data,
  output logic                   m_rdata_valid,
  output logic [7:0]             m_rdata_data,
  output logic                   m_done,
  output logic                   m_iic_csn,
  output logic                   m_iic_scl,
  output logic                   m_iic_sdo,
  output logic                   m_iic_tri,
  input  logic                   m_iic_sdi,
  output logic [WD_ERR_INFO-1:0] m_err_iic_info1
);
  localparam int DIV = (MD_SIM_ABLE != 0) ? 4 : NB_CLK_DIV;
  localparam int CW = $clog2(DIV);
  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP, DONE} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, rdata_q, rdata_d;
  logic [WD_BYTE_CNT-1:0] len_q, len_d;
  logic [3:0] err_q, err_d;
  logic rnw_q, rnw_d, ack_q, ack_d, ready_q, ready_d, wready_q, wready_d;
  logic rvalid_q, rvalid_d, done_q, done_d, csn_q, csn_d, scl_q, scl_d, tri_q, tri_d;
  logic acc, run, tick, q3, last;
  assign acc = s_cmd_valid & ready_q;
  assign run = st_q != IDLE && st_q != DONE;
  assign tick = run && cnt_q == CW'(DIV - 1);
  assign q3 = tick && qtr_q == 2'd3;
  assign last = len_q == WD_BYTE_CNT'(1);
  always_comb begin
    st_d = st_q;
    cnt_d = (tick || !run) ? '0 : cnt_q + CW'(1);
    qtr_d = tick ? qtr_q + 2'd1 : qtr_q;
    bit_d = bit_q;
    sh_d = sh_q;
    len_d = len_q;
    rnw_d = rnw_q;
    err_d = err_q;
    ack_d = (tick && qtr_q == 2'd2) ? m_iic_sdi : ack_q;
    rdata_d = rdata_q;
    wready_d = 1'b0;
    rvalid_d = 1'b0;
    done_d = 1'b0;
    case (st_q)
      IDLE: if (acc) begin
        len_d = s_cmd_len;
        rnw_d = s_cmd_rnw;
        sh_d = {s_cmd_addr, s_cmd_rnw};
        bit_d = 3'd0;
        qtr_d = 2'd0;
        err_d = {s_cmd_len == '0, 3'b000};
        st_d = (s_cmd_len == '0) ? DONE : START;
      end
      START: if (q3) st_d = ADDR;
      ADDR, WR_BYTE: if (q3) begin
        sh_d = {sh_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = (st_q == ADDR) ? ADDR_ACK : WR_ACK;
      end
      ADDR_ACK, WR_ACK: if (q3) begin
        if (ack_q) begin
          err_d = err_q | ((st_q == ADDR_ACK) ? 4'b0001 : 4'b0010);
          st_d = STOP;
        end else begin
          if (st_q == WR_ACK) len_d = len_q - WD_BYTE_CNT'(1);
          if (st_q == WR_ACK && last) st_d = STOP;
          else if (rnw_q) st_d = RD_BYTE;
          else if (s_wdata_valid) begin
            st_d = WR_BYTE;
            wready_d = 1'b1;
            sh_d = s_wdata_data;
          end else begin
            st_d = STOP;
            err_d = err_q | 4'b0100;
          end
        end
      end
      RD_BYTE: begin
        if (tick && qtr_q == 2'd2) begin
          sh_d = {sh_q[6:0], m_iic_sdi};
          rvalid_d = bit_q == 3'd7;
          rdata_d = (bit_q == 3'd7) ? {sh_q[6:0], m_iic_sdi} : rdata_q;
        end
        if (q3) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RD_ACK;
        end
      end
      RD_ACK: if (q3) begin
        len_d = len_q - WD_BYTE_CNT'(1);
        st_d = last ? STOP : RD_BYTE;
      end
      STOP: if (q3) st_d = DONE;
      DONE: begin
        st_d = IDLE;
        done_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase
    // bus pins are derived from the phase being entered so they change only on tick edges
    scl_d = (st_d == START) ? qtr_d != 2'd3 : (st_d == STOP) ? qtr_d != 2'd0 :
            (st_d == IDLE || st_d == DONE) ? 1'b1 : ^qtr_d;
    tri_d = (st_d == START) ? qtr_d == 2'd0 : (st_d == STOP) ? qtr_d[1] :
            (st_d == ADDR || st_d == WR_BYTE) ? sh_d[7] : (st_d == RD_ACK) ? len_d == WD_BYTE_CNT'(1) : 1'b1;
    csn_d = st_d == IDLE || st_d == DONE;
    ready_d = st_d == IDLE;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      qtr_q <= 2'd0;
      bit_q <= 3'd0;
      sh_q <= 8'h00;
      rdata_q <= 8'h00;
      len_q <= '0;
      err_q <= 4'h0;
      rnw_q <= 1'b0;
      ack_q <= 1'b0;
      ready_q <= 1'b0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      done_q <= 1'b0;
      csn_q <= 1'b1;
      scl_q <= 1'b1;
      tri_q <= 1'b1;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      rdata_q <= rdata_d;
      len_q <= len_d;
      err_q <= err_d;
      rnw_q <= rnw_d;
      ack_q <= ack_d;
      ready_q <= ready_d;
      wready_q <= wready_d;
      rvalid_q <= rvalid_d;
      done_q <= done_d;
      csn_q <= csn_d;
      scl_q <= scl_d;
      tri_q <= tri_d;
    end
  end
  assign s_cmd_ready = ready_q;
  assign s_wdata_ready = wready_q;
  assign m_rdata_valid = rvalid_q;
  assign m_rdata_data = rdata_q;
  assign m_done = done_q;
  assign m_iic_csn = csn_q;
  assign m_iic_scl = scl_q;
  assign m_iic_sdo = 1'b0;
  assign m_iic_tri = tri_q;
  assign m_err_iic_info1 = WD_ERR_INFO'(err_q);
endmodule

// File: tb/tb_iic_master_port.sv
// tb_iic_master_port: directed bench with a bit-level IIC slave model and frame/readback scoreboards
module tb_iic_master_port;
  logic clk = 1'b0, rst = 1'b1;
  logic s_cmd_valid = 1'b0, s_cmd_rnw = 1'b0, s_wdata_valid = 1'b0;
  logic s_cmd_ready, s_wdata_ready, m_rdata_valid, m_done;
  logic m_iic_csn, m_iic_scl, m_iic_sdo, m_iic_tri, m_iic_sdi;
  logic [6:0] s_cmd_addr = 7'h00;
  logic [7:0] s_cmd_len = 8'h00, s_wdata_data = 8'h00, m_rdata_data;
  logic [3:0] m_err_iic_info1;
  logic slv = 1'b1, addr_nack = 1'b0, rnw_s = 1'b0, in_x = 1'b0;
  logic p_scl = 1'b1, p_line = 1'b1, p_csn = 1'b1, line;
  logic [8:0] fr = 9'h000;
  logic [7:0] sl_rd [4];
  int n_rd = 0, nb = 0, cyc = 0, acc_cyc = 0, done_cyc = 0, csn_low = 0;
  int done_n = 0, wr_n = 0, rd_n = 0, checks = 0, errors = 0;
  logic [8:0] exp_q [$];
  logic [7:0] rd_exp [$];
  logic [7:0] wq [$];
  assign m_iic_sdi = m_iic_tri & slv;
  always #5 clk = ~clk;
  iic_master_port #(.MD_SIM_ABLE(1)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
    .s_cmd_rnw(s_cmd_rnw), .s_cmd_len(s_cmd_len),
    .s_wdata_valid(s_wdata_valid), .s_wdata_ready(s_wdata_ready), .s_wdata_data(s_wdata_data),
    .m_rdata_valid(m_rdata_valid), .m_rdata_data(m_rdata_data), .m_done(m_done),
    .m_iic_csn(m_iic_csn), .m_iic_scl(m_iic_scl), .m_iic_sdo(m_iic_sdo),
    .m_iic_tri(m_iic_tri), .m_iic_sdi(m_iic_sdi), .m_err_iic_info1(m_err_iic_info1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic upd_w();
    s_wdata_valid = wq.size() > 0;
    s_wdata_data = s_wdata_valid ? wq[0] : 8'h00;
  endtask
  task automatic step();
    logic [31:0] want;
    @(posedge clk);
    #1;
    cyc++;
    line = m_iic_tri & slv;
    if (!m_iic_csn) csn_low++;
    if (m_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (s_wdata_ready) begin
      wr_n++;
      if (wq.size() > 0) void'(wq.pop_front());
    end
    upd_w();
    if (m_rdata_valid) begin
      rd_n++;
      want = 32'hdead;
      if (rd_exp.size() > 0) want = 32'(rd_exp.pop_front());
      chk("rdata", 32'(m_rdata_data), want);
    end
    if (m_iic_scl && p_scl && p_line && !line) begin
      in_x = 1'b1;
      nb = 0;
      slv = 1'b1;
    end else if (m_iic_scl && p_scl && !p_line && line) begin
      in_x = 1'b0;
    end else if (in_x && m_iic_scl && !p_scl) begin
      fr = {fr[7:0], line};
      nb++;
      if (nb == 8) rnw_s = line;
      if (nb % 9 == 0) begin
        want = 32'hdead;
        if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
        chk("frame", 32'(fr), want);
      end
    end else if (in_x && !m_iic_scl && p_scl) begin
      slv = (nb % 9 == 8) ? (nb < 9 ? addr_nack : rnw_s) :
            (rnw_s && nb >= 9 && nb / 9 <= n_rd) ? sl_rd[nb / 9 - 1][7 - nb % 9] : 1'b1;
    end
    p_scl = m_iic_scl;
    p_line = m_iic_tri & slv;
    p_csn = m_iic_csn;
  endtask
  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] n);
    int w = 0;
    while (!s_cmd_ready && w < 50) begin
      step();
      w++;
    end
    chk("cmd_ready", 32'(s_cmd_ready), 32'd1);
    s_cmd_addr = a;
    s_cmd_rnw = r;
    s_cmd_len = n;
    s_cmd_valid = 1'b1;
    csn_low = 0;
    done_n = 0;
    wr_n = 0;
    rd_n = 0;
    step();
    acc_cyc = cyc;
    s_cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int w = 0;
    while (done_n == 0 && w < lim) begin
      step();
      w++;
    end
    chk("done_seen", 32'(done_n), 32'd1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_cmd_ready), 32'd0);
    chk("rst_pins", {28'd0, m_iic_csn, m_iic_scl, m_iic_tri, m_iic_sdo}, 32'hE);
    chk("rst_pulses", {29'd0, s_wdata_ready, m_rdata_valid, m_done}, 32'd0);
    chk("rst_rdata", 32'(m_rdata_data), 32'd0);
    chk("rst_err", 32'(m_err_iic_info1), 32'd0);
    #2 rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(s_cmd_ready), 32'd1);
    // two-byte write, slave acks everything
    wq = '{8'hA5, 8'h0F};
    upd_w();
    exp_q = '{{8'h78, 1'b0}, {8'hA5, 1'b0}, {8'h0F, 1'b0}};
    issue(7'h3C, 1'b0, 8'd2);
    chk("csn_fall", 32'(m_iic_csn), 32'd0);
    chk("ready_drop", 32'(s_cmd_ready), 32'd0);
    wait_done(1000);
    chk("wr_done_lat", 32'(done_cyc - acc_cyc), 32'd465);
    chk("wr_csn_low", 32'(csn_low), 32'd464);
    chk("wr_pulses", 32'(wr_n), 32'd2);
    chk("wr_err", 32'(m_err_iic_info1), 32'd0);
    chk("wr_ready_back", 32'(s_cmd_ready), 32'd1);
    chk("wr_frames_left", 32'(exp_q.size()), 32'd0);
    chk("sdo_zero", 32'(m_iic_sdo), 32'd0);
    // three-byte read, master ACK, ACK, NACK
    sl_rd[0] = 8'h11;
    sl_rd[1] = 8'h22;
    sl_rd[2] = 8'h33;
    n_rd = 3;
    exp_q = '{{8'hA1, 1'b0}, {8'h11, 1'b0}, {8'h22, 1'b0}, {8'h33, 1'b1}};
    rd_exp = '{8'h11, 8'h22, 8'h33};
    issue(7'h50, 1'b1, 8'd3);
    wait_done(1000);
    chk("rd_done_lat", 32'(done_cyc - acc_cyc), 32'd609);
    chk("rd_count", 32'(rd_n), 32'd3);
    chk("rd_left", 32'(rd_exp.size()), 32'd0);
    chk("rd_frames_left", 32'(exp_q.size()), 32'd0);
    chk("rd_hold", 32'(m_rdata_data), 32'h33);
    chk("rd_err", 32'(m_err_iic_info1), 32'd0);
    // address NACK aborts before any data phase
    addr_nack = 1'b1;
    wq = '{8'h99};
    upd_w();
    exp_q = '{{8'h54, 1'b1}};
    issue(7'h2A, 1'b0, 8'd1);
    wait_done(1000);
    chk("nack_done_lat", 32'(done_cyc - acc_cyc), 32'd177);
    chk("nack_err", 32'(m_err_iic_info1), 32'h1);
    chk("nack_no_data", 32'(wr_n), 32'd0);
    chk("nack_frames_left", 32'(exp_q.size()), 32'd0);
    addr_nack = 1'b0;
    // write data underflow on the second byte
    wq = '{8'hC3};
    upd_w();
    exp_q = '{{8'h78, 1'b0}, {8'hC3, 1'b0}};
    issue(7'h3C, 1'b0, 8'd2);
    wait_done(1000);
    chk("uf_done_lat", 32'(done_cyc - acc_cyc), 32'd321);
    chk("uf_err", 32'(m_err_iic_info1), 32'h4);
    chk("uf_pulses", 32'(wr_n), 32'd1);
    chk("uf_frames_left", 32'(exp_q.size()), 32'd0);
    // zero-length command
    issue(7'h10, 1'b0, 8'd0);
    chk("z_err", 32'(m_err_iic_info1), 32'h8);
    chk("z_early", {29'd0, m_done, s_cmd_ready, m_iic_csn}, 32'd1);
    step();
    chk("z_done", {29'd0, m_done, s_cmd_ready, m_iic_csn}, 32'd7);
    // next command clears errors, then reset lands mid-read
    sl_rd[0] = 8'hDE;
    sl_rd[1] = 8'hAD;
    sl_rd[2] = 8'hBE;
    exp_q = '{{8'hA1, 1'b0}, {8'hDE, 1'b0}, {8'hAD, 1'b0}, {8'hBE, 1'b1}};
    rd_exp = '{8'hDE, 8'hAD, 8'hBE};
    issue(7'h50, 1'b1, 8'd3);
    chk("clr_err", 32'(m_err_iic_info1), 32'd0);
    repeat (150) step();
    chk("mid_csn", 32'(m_iic_csn), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_pins", {29'd0, m_iic_csn, m_iic_scl, m_iic_tri}, 32'd7);
    chk("arst_ready", {30'd0, s_cmd_ready, m_done}, 32'd0);
    #1 rst = 1'b0;
    slv = 1'b1;
    in_x = 1'b0;
    p_scl = 1'b1;
    p_line = 1'b1;
    p_csn = 1'b1;
    exp_q.delete();
    rd_exp.delete();
    done_n = 0;
    step();
    chk("rel_ready", 32'(s_cmd_ready), 32'd1);
    repeat (3) step();
    chk("rst_no_done", 32'(done_n), 32'd0);
    wq = '{8'h5A};
    upd_w();
    exp_q = '{{8'h78, 1'b0}, {8'h5A, 1'b0}};
    issue(7'h3C, 1'b0, 8'd1);
    wait_done(1000);
    chk("post_done_lat", 32'(done_cyc - acc_cyc), 32'd321);
    chk("post_err", 32'(m_err_iic_info1), 32'd0);
    chk("post_pulses", 32'(wr_n), 32'd1);
    chk("post_frames_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
